// File: rtl/song_recorder_pkg.sv
// Shared definitions for the song recorder: note byte layout, defaults and FSM states.
package song_pkg;

    localparam int DUR_MSB  = 7;
    localparam int DUR_LSB  = 4;
    localparam int TONE_MSB = 3;
    localparam int TONE_LSB = 0;

    localparam int         DUR_MAX_DEF = 15;
    localparam logic [3:0] REST_TONE   = 4'd0;
    localparam logic [7:0] PAD_BYTE    = 8'h10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REC  = 2'd1,
        ST_PAD  = 2'd2
    } rec_state_e;

    function automatic logic [7:0] pack_note(input logic [3:0] dur, input logic [3:0] tone);
        logic [7:0] b;
        b                    = '0;
        b[DUR_MSB:DUR_LSB]   = dur;
        b[TONE_MSB:TONE_LSB] = tone;
        return b;
    endfunction

endpackage

// File: rtl/song_recorder_if.sv
// Tone-input and RAM-write-port bundle between the keypad side and the song recorder.
interface song_recorder_if;

    logic       tick;
    logic [3:0] tone_in;
    logic       rec_start;
    logic       rec_stop;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       recording;
    logic       full;
    logic [7:0] song_len;

    modport master (
        output tick, tone_in, rec_start, rec_stop,
        input  mem_we, mem_addr, mem_data, recording, full, song_len
    );

    modport slave (
        input  tick, tone_in, rec_start, rec_stop,
        output mem_we, mem_addr, mem_data, recording, full, song_len
    );

endinterface

// File: rtl/song_recorder_note_dur_counter.sv
// Duration counter for the note being captured: counts ticks, saturates at DUR_MAX
// and flags the tick that completes a full-length segment so the note is split.
module note_dur_counter
    import song_pkg::*;
#(
    parameter int DUR_MAX = DUR_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       clr_i,
    input  logic       tick_i,
    output logic [3:0] dur_o,
    output logic       split_o
);

    localparam logic [3:0] DUR_LIM = 4'(DUR_MAX);

    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cnt_inc;

    // dur_o already includes this cycle's tick, so the change rules see the updated count
    always_comb begin
        cnt_inc = cnt_q;
        if (tick_i && (cnt_q < DUR_LIM)) cnt_inc = cnt_q + 4'd1;
    end

    assign dur_o   = cnt_inc;
    assign split_o = en_i && tick_i && (cnt_inc == DUR_LIM);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || split_o) cnt_d = '0;
        else if (en_i)        cnt_d = cnt_inc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/song_recorder.sv
// song_recorder: turns a live tone stream into {dur, tone} note bytes on the song RAM write port.
// Define SONG_RECORDER_PAD_EN to fill the remaining addresses with 1-tick rests after a stop.
module song_recorder
    import song_pkg::*;
#(
    parameter int MAX_ADDR = 20,
    parameter int DUR_MAX  = DUR_MAX_DEF
) (
    input logic            clk,
    input logic            rst,
    song_recorder_if.slave bus
);

    localparam logic [7:0] LAST_ADDR = 8'(MAX_ADDR);

`ifdef SONG_RECORDER_PAD_EN
    localparam rec_state_e STOP_STATE = ST_PAD;
`else
    localparam rec_state_e STOP_STATE = ST_IDLE;
`endif

    rec_state_e state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [3:0] cur_tone_q, cur_tone_d;
    logic       mem_we_q, mem_we_d;
    logic [7:0] mem_addr_q, mem_addr_d;
    logic [7:0] mem_data_q, mem_data_d;
    logic       recording_q, recording_d;
    logic       full_q, full_d;
    logic       pad_q, pad_d;
    logic [7:0] song_len_q, song_len_d;

    logic [3:0] dur_next;
    logic       split;
    logic       emit, emit_pad, cnt_en, cnt_clr, tone_ld, restart;
    logic [7:0] emit_byte;
    logic       tone_chg, at_max;

    assign tone_chg = (bus.tone_in != cur_tone_q);
    assign at_max   = (addr_q == LAST_ADDR);

    note_dur_counter #(.DUR_MAX(DUR_MAX)) u_dur (
        .clk    (clk),
        .rst    (rst),
        .en_i   (cnt_en),
        .clr_i  (cnt_clr),
        .tick_i (bus.tick),
        .dur_o  (dur_next),
        .split_o(split)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.rec_start) state_d = ST_REC;
            ST_REC: begin
                if (restart)              state_d = ST_REC;
                else if (emit && at_max)  state_d = ST_IDLE;
                else if (bus.rec_stop)    state_d = STOP_STATE;
            end
`ifdef SONG_RECORDER_PAD_EN
            ST_PAD:  if (at_max) state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // A split, change or stop all close the note with the tick-inclusive count
    always_comb begin
        emit      = 1'b0;
        emit_pad  = 1'b0;
        emit_byte = pack_note(dur_next, cur_tone_q);
        cnt_en    = 1'b0;
        cnt_clr   = 1'b0;
        tone_ld   = 1'b0;
        restart   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.rec_start) begin
                    restart = 1'b1;
                    cnt_clr = 1'b1;
                    tone_ld = 1'b1;
                end
            end
            ST_REC: begin
                if (bus.rec_start) begin
                    restart = 1'b1;
                    cnt_clr = 1'b1;
                    tone_ld = 1'b1;
                end else begin
                    cnt_en  = 1'b1;
                    emit    = split || ((bus.rec_stop || tone_chg) && (dur_next != 4'd0));
                    cnt_clr = bus.rec_stop || tone_chg;
                    tone_ld = !bus.rec_stop && tone_chg;
                end
            end
            ST_PAD: begin
                emit      = 1'b1;
                emit_pad  = 1'b1;
                emit_byte = PAD_BYTE;
            end
            default: ;
        endcase
    end

    // song_len trails the write strobe by one cycle and ignores pad bytes
    always_comb begin
        addr_d      = addr_q;
        cur_tone_d  = cur_tone_q;
        mem_we_d    = emit;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        pad_d       = emit_pad;
        full_d      = full_q;
        song_len_d  = song_len_q;
        recording_d = (state_d != ST_IDLE);
        if (emit) begin
            mem_addr_d = addr_q;
            mem_data_d = emit_byte;
            addr_d     = addr_q + 8'd1;
            if (!emit_pad && at_max) full_d = 1'b1;
        end
        if (tone_ld) cur_tone_d = bus.tone_in;
        if (mem_we_q && !pad_q) song_len_d = song_len_q + 8'd1;
        if (restart) begin
            addr_d     = '0;
            full_d     = 1'b0;
            song_len_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q      <= '0;
            cur_tone_q  <= REST_TONE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            pad_q       <= 1'b0;
            full_q      <= 1'b0;
            song_len_q  <= '0;
            recording_q <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            cur_tone_q  <= cur_tone_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            pad_q       <= pad_d;
            full_q      <= full_d;
            song_len_q  <= song_len_d;
            recording_q <= recording_d;
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_data  = mem_data_q;
    assign bus.recording = recording_q;
    assign bus.full      = full_q;
    assign bus.song_len  = song_len_q;

endmodule
